sram_controller: RTL

Memory-stage responder for the load/store requests raised by the instruction decoder's `mem_read` / `mem_write` control bits. It converts one 32-bit word access into two sequential 16-bit accesses on the external asynchronous SRAM, and holds `ready` low so the pipeline stalls until the word is complete. It sits between the MEM stage and the board SRAM pins. The tri-state data bus is resolved at the top level.

---
 rtl/sram_controller.sv | 118 +++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// sram_controller: splits one 32-bit load/store into two 16-bit accesses on
// an asynchronous SRAM. The pipeline is stalled by holding ready low until the
// whole word has completed.
module sram_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int unsigned CW = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [16:0]   word_q;
  logic [31:0]   data_q;
  logic          op_wr;
  logic [31:0]   offset;
  logic          req;
  logic          req_wr;
  logic          unused_offset_bits;

  // Byte address relative to the SRAM window; only the word index is used.
  assign offset             = address - BASE_ADDR;
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign cnt_inc            = cnt + CW'(1);
  assign req                = rd_en | wr_en;
  // A simultaneous read and write request is treated as a read.
  assign req_wr             = wr_en & ~rd_en;

  // Stall the pipeline except when idle without a request or finishing a word.
  assign ready = (state == DONE) || ((state == IDLE) && !req);

  // Access sequencer; pins are registered with the values of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      word_q      <= '0;
      data_q      <= '0;
      op_wr       <= 1'b0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            state      <= LOW;
            cnt        <= '0;
            word_q     <= offset[18:2];
            data_q     <= write_data;
            op_wr      <= req_wr;
            sram_addr  <= {offset[18:2], 1'b0};
            if (req_wr) sram_dq_out <= write_data[15:0];
            sram_dq_oe <= req_wr;
            sram_we_n  <= ~req_wr;
            sram_oe_n  <= req_wr;
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            state     <= HIGH;
            cnt       <= '0;
            sram_addr <= {word_q, 1'b1};
            if (op_wr) sram_dq_out <= data_q[31:16];
            sram_we_n <= ~op_wr;
            if (!op_wr) read_data[15:0] <= sram_dq_in;
          end else begin
            cnt       <= cnt_inc;
            // Release the strobe one cycle early so data/address outlast it.
            sram_we_n <= ~(op_wr && (cnt_inc != LAST));
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            state      <= DONE;
            cnt        <= '0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!op_wr) read_data[31:16] <= sram_dq_in;
          end else begin
            cnt       <= cnt_inc;
            sram_we_n <= ~(op_wr && (cnt_inc != LAST));
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
